// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with valid/ready handshakes, registered outputs and flags
// Optional iterative unsigned divider built when ALU_DIV_EN is defined.
module alu_mc #(
  parameter int N   = 20,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   Opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic [N-1:0] Rem,
  output logic         Z,
  output logic         C,
  output logic         DZ,
  output logic         busy
);
  localparam logic [N-1:0] NL = N'(N);
  logic [N:0] sum, dif;
  logic [2*N-1:0] prod;
  logic [N-1:0] res_c, rem_c, shl, shr;
  logic c_c, dz_c, accept, pop;
  assign sum  = {1'b0, A} + {1'b0, B};
  assign dif  = {1'b0, A} - {1'b0, B};
  assign prod = {{N{1'b0}}, A} * {{N{1'b0}}, B};
  assign shl  = B >= NL ? '0 : A << B[SHW-1:0];
  assign shr  = B >= NL ? '0 : A >> B[SHW-1:0];
  assign pop    = out_valid && out_ready;
  assign accept = in_valid && in_ready;
  always_comb begin
    res_c = sum[N-1:0];
    rem_c = '0;
    c_c   = sum[N];
    dz_c  = 1'b0;
    case (Opcode)
      4'b0001: begin res_c = dif[N-1:0]; c_c = dif[N]; end
      4'b0010: begin res_c = prod[N-1:0]; c_c = |prod[2*N-1:N]; end
      4'b0011: begin
        c_c  = 1'b0;
        dz_c = 1'b1;
`ifdef ALU_DIV_EN
        res_c = '1;
        rem_c = A;
`else
        res_c = '0;
`endif
      end
      4'b0100: begin res_c = A & B; c_c = 1'b0; end
      4'b0101: begin res_c = A | B; c_c = 1'b0; end
      4'b0110: begin res_c = shl; c_c = 1'b0; end
      4'b0111: begin res_c = shr; c_c = 1'b0; end
      4'b1000: begin res_c = {{(N-2){1'b0}}, A >= B, A < B}; c_c = 1'b0; end
      default: ;
    endcase
  end
`ifdef ALU_DIV_EN
  localparam logic [0:0] IDLE = 1'b0, DIV = 1'b1;
  localparam logic [SHW-1:0] LAST = SHW'(N - 1);
  logic state, multi, ge;
  logic [N-1:0] dq, dr, dd, rn, qn;
  logic [N:0] rs;
  logic [SHW-1:0] cnt;
  assign multi    = Opcode == 4'b0011 && B != '0;
  assign in_ready = state == IDLE && (!out_valid || out_ready);
  assign busy     = state == DIV;
  assign rs = {dr, dq[N-1]};
  assign ge = rs >= {1'b0, dd};
  assign rn = ge ? N'(rs - {1'b0, dd}) : rs[N-1:0];
  assign qn = {dq[N-2:0], ge};
`else
  logic multi;
  assign multi    = 1'b0;
  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Rem       <= '0;
      Z         <= 1'b1;
      C         <= 1'b0;
      DZ        <= 1'b0;
`ifdef ALU_DIV_EN
      state     <= IDLE;
      cnt       <= '0;
      dq        <= '0;
      dr        <= '0;
      dd        <= '0;
`endif
    end else begin
      if (pop) out_valid <= 1'b0;
      if (accept && !multi) begin
        out_valid <= 1'b1;
        Result    <= res_c;
        Rem       <= rem_c;
        Z         <= res_c == '0;
        C         <= c_c;
        DZ        <= dz_c;
      end
`ifdef ALU_DIV_EN
      if (accept && multi) begin
        state <= DIV;
        cnt   <= '0;
        dq    <= A;
        dr    <= '0;
        dd    <= B;
      end
      // restoring division: one quotient bit per cycle, MSB first
      if (state == DIV) begin
        dq  <= qn;
        dr  <= rn;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state     <= IDLE;
          out_valid <= 1'b1;
          Result    <= qn;
          Rem       <= rn;
          Z         <= qn == '0;
          C         <= 1'b0;
          DZ        <= 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc; expectations come from a behavioural model
module tb_alu_mc;
  localparam int N = 20;
  typedef struct packed {
    logic [N-1:0] res;
    logic [N-1:0] rem;
    logic z;
    logic c;
    logic dz;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, rnd = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic [3:0] op = '0;
  logic in_ready, out_valid, z, c, dz, busy;
  logic [N-1:0] result, rem;
  exp_t sb[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  alu_mc #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .Opcode(op), .out_valid(out_valid), .out_ready(out_ready), .Result(result),
    .Rem(rem), .Z(z), .C(c), .DZ(dz), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    logic [63:0] w;
    e = '0;
    case (o)
      4'd1: begin e.res = x - y; e.c = x < y; end
      4'd2: begin w = 64'(x) * 64'(y); e.res = w[N-1:0]; e.c = (w >> N) != 0; end
      4'd3: begin
`ifdef ALU_DIV_EN
        if (y == 0) begin e.res = '1; e.rem = x; e.dz = 1'b1; end
        else begin e.res = x / y; e.rem = x % y; end
`else
        e.dz = 1'b1;
`endif
      end
      4'd4: e.res = x & y;
      4'd5: e.res = x | y;
      4'd6: e.res = 32'(y) >= N ? '0 : x << y;
      4'd7: e.res = 32'(y) >= N ? '0 : x >> y;
      4'd8: e.res = x < y ? N'(1) : N'(2);
      default: begin w = 64'(x) + 64'(y); e.res = w[N-1:0]; e.c = w[N]; end
    endcase
    e.z = e.res == '0;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("rem", rem, e.rem);
        check("z", z, e.z);
        check("c", c, e.c);
        check("dz", dz, e.dz);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end
  task automatic issue(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    bit ok = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin sb.push_back(model(o, x, y)); ok = 1; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1;
    end
    check("drain", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    bit bad_rdy, bad_busy;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    issue(4'd0, 20'hFFFFF, 20'h00001);
    issue(4'd1, 20'h3, 20'h5);
    issue(4'd2, 20'hFFFFF, 20'h2);
    issue(4'd2, 20'h3FF, 20'h3FF);
    issue(4'd4, 20'hF0F0F, 20'h0FF00);
    issue(4'd5, 20'hF0F0F, 20'h0FF00);
    issue(4'd6, 20'h00001, 20'd19);
    issue(4'd6, 20'h00001, 20'd20);
    issue(4'd7, 20'h80000, 20'd19);
    issue(4'd7, 20'hFFFFF, 20'hFFFFF);
    issue(4'd8, 20'h00007, 20'h00007);
    issue(4'd8, 20'h00002, 20'h00009);
    issue(4'd15, 20'h12345, 20'h11111);
    drain();
    issue(4'd3, 20'h5, 20'h0);
    @(negedge clk);
    check("dz_latency", out_valid, 1);
    drain();
    issue(4'd3, 20'd100, 20'd7);
`ifdef ALU_DIV_EN
    cnt = 0; bad_rdy = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      cnt++;
      bad_rdy |= in_ready;
      bad_busy |= !busy;
    end
    check("div_latency", 64'(cnt), 64'(N));
    check("div_in_ready_low", bad_rdy, 0);
    check("div_busy_high", bad_busy, 0);
`else
    @(negedge clk);
    check("div_trap_latency", out_valid, 1);
`endif
    drain();
    out_ready = 1'b0;
    issue(4'd0, 20'd1, 20'd2);
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_hold", result, 20'd3);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    #1 check("stall_release_ready", in_ready, 1);
    issue(4'd1, 20'd10, 20'd4);
    issue(4'd2, 20'd6, 20'd7);
    issue(4'd8, 20'd9, 20'd2);
    drain();
`ifdef ALU_DIV_EN
    issue(4'd3, 20'd1000, 20'd3);
    repeat (9) @(posedge clk);
    #1 check("busy_mid_div", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    issue(4'd8, 20'd2, 20'd9);
    drain();
`endif
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] o;
      logic [N-1:0] x, y;
      o = 4'($urandom_range(0, 9));
      x = N'($urandom);
      y = $urandom_range(0, 3) == 0 ? N'($urandom_range(0, 24)) : N'($urandom);
      issue(o, x, y);
    end
    rnd = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
